// File: rtl/board_write_ctrl.sv
// Row-write sequencer for the 16-row GoBang board memory.
// It arbitrates a full-board clear sweep against read-check-write stone placement.
module board_write_ctrl #(
  parameter int COLS   = 16,
  parameter int CELL_W = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear_req,
  input  logic                     mv_valid,
  output logic                     mv_ready,
  input  logic [3:0]               mv_row,
  input  logic [3:0]               mv_col,
  input  logic                     mv_color,
  output logic                     mv_done,
  output logic                     mv_reject,
  output logic                     clear_done,
  output logic                     busy,
  output logic [3:0]               mem_sel,
  output logic                     mem_we,
  output logic [COLS*CELL_W-1:0]   mem_wdata,
  input  logic [COLS*CELL_W-1:0]   mem_rdata
);

  localparam int ROW_W = COLS * CELL_W;

  typedef enum logic [1:0] {IDLE, CLEAR, READ, WRITE} state_t;

  state_t             state_reg;
  logic [3:0]         cnt_reg;
  logic [3:0]         row_reg;
  logic [3:0]         col_reg;
  logic               color_reg;
  logic               clear_pend_reg;
  logic [ROW_W-1:0]   rowbuf_reg;
  logic               mv_done_reg;
  logic               mv_reject_reg;
  logic               clear_done_reg;

  logic [CELL_W-1:0]  cell_rd;
  logic [CELL_W-1:0]  color_code;
  logic [ROW_W-1:0]   merged_row;

  assign cell_rd    = mem_rdata[CELL_W*col_reg +: CELL_W];
  assign color_code = color_reg ? CELL_W'(2) : CELL_W'(1);

  // Rebuild the row from the buffered read, swapping in only the target cell.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_merge
    assign merged_row[gi*CELL_W +: CELL_W] =
      (col_reg == 4'(gi)) ? color_code : rowbuf_reg[gi*CELL_W +: CELL_W];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      color_reg      <= 1'b0;
      clear_pend_reg <= 1'b0;
      rowbuf_reg     <= '0;
      mv_done_reg    <= 1'b0;
      mv_reject_reg  <= 1'b0;
      clear_done_reg <= 1'b0;
    end else begin
      mv_done_reg    <= 1'b0;
      mv_reject_reg  <= 1'b0;
      clear_done_reg <= 1'b0;
      if (clear_req && state_reg != CLEAR)
        clear_pend_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          // A pending clear beats a new move; entering CLEAR consumes the request.
          if (clear_pend_reg) begin
            state_reg      <= CLEAR;
            cnt_reg        <= '0;
            clear_pend_reg <= 1'b0;
          end else if (mv_valid) begin
            row_reg   <= mv_row;
            col_reg   <= mv_col;
            color_reg <= mv_color;
            state_reg <= READ;
          end
        end
        CLEAR: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == 4'd15) begin
            state_reg      <= IDLE;
            clear_done_reg <= 1'b1;
          end
        end
        READ: begin
          rowbuf_reg <= mem_rdata;
          if (cell_rd != '0) begin
            state_reg     <= IDLE;
            mv_reject_reg <= 1'b1;
          end else begin
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          state_reg   <= IDLE;
          mv_done_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mv_done    = mv_done_reg;
  assign mv_reject  = mv_reject_reg;
  assign clear_done = clear_done_reg;
  assign mv_ready   = (state_reg == IDLE) && !clear_pend_reg;
  assign busy       = (state_reg != IDLE) || clear_pend_reg;
  assign mem_we     = (state_reg == CLEAR) || (state_reg == WRITE);
  assign mem_sel    = (state_reg == CLEAR) ? cnt_reg :
                      (state_reg == READ || state_reg == WRITE) ? row_reg : 4'd0;
  assign mem_wdata  = (state_reg == WRITE) ? merged_row : '0;

endmodule

// File: doc/board_write_ctrl.md
# board_write_ctrl

Sequencing controller for the 16-row GoBang board memory. It owns the board's single row-write port, whose 4-bit row select and write enable drive the 4-to-16 row-enable decoder. It shares that port between two requesters: a full-board clear sweep and player stone placement. Placement uses a read-check-write sequence, so an occupied cell is never overwritten.

## Interface
Parameters:
- COLS, 16, cells per row (one row per decoder output)
- CELL_W, 2, bits per cell; encoding 00 empty, 01 black, 10 white, 11 unused

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- clear_req  in  1  single-cycle pulse requesting a board clear; latched internally
- mv_valid  in  1  move request valid
- mv_ready  out  1  controller accepts a move this cycle
- mv_row  in  4  target row (0..15)
- mv_col  in  4  target column (0..COLS-1)
- mv_color  in  1  0 = black (01), 1 = white (10)
- mv_done  out  1  one-cycle pulse: stone written
- mv_reject  out  1  one-cycle pulse: target cell occupied, nothing written
- clear_done  out  1  one-cycle pulse: all 16 rows zeroed
- busy  out  1  state != IDLE or clear pending
- mem_sel  out  4  row index; drives decoder select and the memory read mux
- mem_we  out  1  drives decoder enable; one row written per asserted cycle
- mem_wdata  out  COLS*CELL_W  full-row write data
- mem_rdata  in  COLS*CELL_W  combinational read of row mem_sel

## Operation
- FSM states: IDLE, CLEAR, READ, WRITE.
- clear_pend register:
  - Set by clear_req in any state except CLEAR.
  - Cleared on entry to CLEAR.
  - clear_req during CLEAR is ignored.
- IDLE:
  - mem_we=0, mem_sel=0, mem_wdata=0.
  - mv_ready = ~clear_pend.
  - Priority: clear_pend over a move. If clear_pend, go to CLEAR with cnt=0.
  - Otherwise, if mv_valid, accept the move: latch row, col and color, then go to READ.
- CLEAR:
  - mem_we=1, mem_sel=cnt, mem_wdata=0.
  - cnt (4-bit) increments each cycle.
  - At cnt=15, go to IDLE and set the clear_done pulse.
  - Exactly 16 write cycles, rows 0..15 in order; no wrap or repeat.
- READ:
  - mem_we=0, mem_sel=latched row.
  - Register mem_rdata into rowbuf.
  - Cell field is bits [CELL_W*col+1 : CELL_W*col].
  - Field != 00: go to IDLE and set the mv_reject pulse.
  - Field == 00: go to WRITE.
- WRITE:
  - mem_we=1, mem_sel=latched row.
  - mem_wdata = rowbuf with only the target field replaced by the color code.
  - Go to IDLE and set the mv_done pulse.
- Moves are never preempted. A clear_req during READ/WRITE is latched and served in the first IDLE cycle after the move, before any new move.
- mv_valid while mv_ready=0: request is not accepted; the requester must hold it.
- Inputs mv_row/col/color are only sampled on the acceptance cycle.

## Timing
- Reset:
  - At any rising edge with resetn=0: state=IDLE, cnt=0, clear_pend=0, rowbuf=0, all pulses 0.
  - Next cycle outputs: mem_we=0, mem_sel=0, mem_wdata=0, busy=0, mv_ready=1.
  - Reset mid-CLEAR or mid-move aborts it; rows already written stay written; no done/reject pulse.
- Move accepted at edge T:
  - READ in cycle T+1, WRITE (mem_we=1) in T+2, IDLE with mv_done=1 in T+3.
  - Reject case: IDLE with mv_reject=1 in T+2.
  - mv_ready is low during READ/WRITE, so back-to-back moves are spaced 3 cycles, or 2 on reject.
- Clear:
  - clear_req at edge T while IDLE: clear_pend=1 in T+1, so mv_ready=0.
  - CLEAR cycles T+2..T+17; IDLE with clear_done=1 in T+18.
- Simultaneous clear_req and mv_valid in IDLE with clear_pend=0:
  - The move is accepted.
  - The clear is latched and starts after the move completes.
- Pulses are registered, high for exactly one cycle, and coincide with the first IDLE cycle.

## Test plan
- Reset, then clear_req pulse: mem_we high for 16 consecutive cycles with mem_sel 0..15 and mem_wdata=0; clear_done one cycle after mem_sel=15; busy falls with clear_done.
- Move row 3, col 5, black, into an empty board: mem_sel=3 in READ; WRITE mem_wdata has bits[11:10]=01 and all else 0; mv_done at T+3.
- Repeat the same move with white: mv_reject at T+2; mem_we stays 0 throughout.
- Move row 15, col 15, white, into row with mem_rdata=32'h0000_0001: WRITE data = 32'h8000_0001 (boundary column, neighbours preserved).
- clear_req pulsed during READ of a move: move completes with mv_done; CLEAR starts the cycle after; mv_valid held meanwhile stays unaccepted until clear_done.
- resetn low during CLEAR at cnt=7: next cycle mem_we=0, busy=0, no clear_done; new move accepted immediately after reset release.
